key_command_arbiter: RTL and testbench

- Shares the single game-logic command input between two player keyboards.
- Each player has its own PS/2 keyboard decoder, which emits a one-cycle strobe and a 3-bit move code.
- The block buffers each player's codes in a private FIFO and arbitrates round-robin between players.
- It presents one command at a time to game logic over a valid/ready handshake, tagged with the player ID, and enforces a minimum gap between issued commands.

---
 rtl/key_command_arbiter.sv | 136 +++++++++++++
 tb/tb_key_command_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/key_command_arbiter.sv
// Two-player keyboard command arbiter: per-player FIFOs, round-robin selection,
// valid/ready presentation to game logic and a fixed cooldown after every accepted command.
module key_command_arbiter #(
  parameter int DEPTH  = 4,
  parameter int GAP    = 8,
  parameter int DROP_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p0_valid,
  input  logic [2:0]        p0_cmd,
  input  logic              p1_valid,
  input  logic [2:0]        p1_cmd,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [2:0]        cmd_data,
  output logic              cmd_player,
  output logic [DROP_W-1:0] drop_count,
  output logic              busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  localparam logic [2:0]  MAX_CODE = 3'd5;

  typedef enum logic [1:0] {IDLE, PRESENT, COOLDOWN} state_t;

  state_t            state;
  logic [CW-1:0]     cool;
  logic              last;

  logic [2:0]        mem    [2][DEPTH];
  logic [PW-1:0]     rd_ptr [2];
  logic [PW-1:0]     wr_ptr [2];
  logic [PW:0]       count  [2];
  logic [2:0]        in_cmd [2];
  logic [1:0]        in_valid;

  logic [1:0]        push;
  logic [1:0]        drop;
  logic [1:0]        pop;
  logic [1:0]        nonempty;
  logic              select;
  logic              sel;
  logic [DROP_W:0]   drop_sum;

  assign in_cmd[0] = p0_cmd;
  assign in_cmd[1] = p1_cmd;
  assign in_valid  = {p1_valid, p0_valid};

  // NOTE: every signal written here gets a value on every path first, so no latch is inferred.
  always_comb begin
    push     = '0;
    drop     = '0;
    nonempty = '0;
    for (int i = 0; i < 2; i++) begin
      nonempty[i] = (count[i] != '0);
      // Fullness uses the registered count: a pop this cycle does not free the slot.
      push[i] = in_valid[i] && (in_cmd[i] <= MAX_CODE) && (count[i] != FULL);
      drop[i] = in_valid[i] && (in_cmd[i] <= MAX_CODE) && (count[i] == FULL);
    end
    select   = (state == IDLE) && (nonempty != 2'b00);
    sel      = (nonempty == 2'b11) ? ~last : nonempty[1];
    pop      = {select && sel, select && !sel};
    drop_sum = {1'b0, drop_count} + (DROP_W+1)'(drop[0]) + (DROP_W+1)'(drop[1]);
  end

  // NOTE: the FIFO storage is not reset; emptiness is defined by the counts alone.
  always_ff @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= in_cmd[i];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
      drop_count <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        count[i] <= count[i] + (PW+1)'(push[i]) - (PW+1)'(pop[i]);
      end
      drop_count <= drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      cool       <= '0;
      last       <= 1'b1;
      cmd_valid  <= 1'b0;
      cmd_data   <= '0;
      cmd_player <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (select) begin
            cmd_data   <= mem[sel][rd_ptr[sel]];
            cmd_player <= sel;
            cmd_valid  <= 1'b1;
            last       <= sel;
            state      <= PRESENT;
          end
        end
        PRESENT: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            if (GAP > 0) begin
              cool  <= CW'(GAP - 1);
              state <= COOLDOWN;
            end else begin
              state <= IDLE;
            end
          end
        end
        COOLDOWN: begin
          if (cool == '0) state <= IDLE;
          else            cool  <= cool - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (nonempty != 2'b00) || (state != IDLE);

endmodule

// File: tb/tb_key_command_arbiter.sv
// Bench for key_command_arbiter: directed scenarios then random traffic, all outputs
// compared every cycle against a queue-based model that tracks when the arbiter may next select.
module tb_key_command_arbiter;

  localparam int DEPTH  = 4;
  localparam int GAP    = 8;
  localparam int DROP_W = 8;
  localparam int DROP_MAX = (1 << DROP_W) - 1;

  logic              clock = 1'b0;
  logic              reset;
  logic              p0_valid, p1_valid, cmd_ready;
  logic [2:0]        p0_cmd, p1_cmd;
  logic              cmd_valid, cmd_player, busy;
  logic [2:0]        cmd_data;
  logic [DROP_W-1:0] drop_count;

  key_command_arbiter #(.DEPTH(DEPTH), .GAP(GAP), .DROP_W(DROP_W)) dut (
    .clock(clock), .reset(reset),
    .p0_valid(p0_valid), .p0_cmd(p0_cmd),
    .p1_valid(p1_valid), .p1_cmd(p1_cmd),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .cmd_player(cmd_player),
    .drop_count(drop_count), .busy(busy)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  // Reference model: FIFOs as queues, the cooldown as the first cycle index at which selection is allowed.
  int     q0[$];
  int     q1[$];
  int     m_drop = 0;
  bit     m_valid = 0;
  int     m_data = 0;
  int     m_player = 0;
  int     m_last = 1;
  longint cyc = 0;
  longint idle_from = 0;
  bit     m_busy = 0;

  task automatic model_edge(input bit rst, input bit v0, input int c0,
                            input bit v1, input int c1, input bit rdy);
    int s0, s1, sel, n;
    if (rst) begin
      q0.delete(); q1.delete();
      m_drop = 0; m_valid = 0; m_data = 0; m_player = 0; m_last = 1;
      idle_from = cyc + 1;
    end else begin
      s0 = q0.size();
      s1 = q1.size();
      if (m_valid) begin
        if (rdy) begin
          m_valid   = 0;
          idle_from = cyc + GAP + 1;
        end
      end else if (cyc >= idle_from && (s0 > 0 || s1 > 0)) begin
        if (s0 > 0 && s1 > 0) sel = 1 - m_last;
        else                  sel = (s0 > 0) ? 0 : 1;
        if (sel == 0) m_data = q0.pop_front();
        else          m_data = q1.pop_front();
        m_player = sel;
        m_last   = sel;
        m_valid  = 1;
      end
      n = 0;
      if (v0 && c0 <= 5) begin
        if (s0 == DEPTH) n++;
        else q0.push_back(c0);
      end
      if (v1 && c1 <= 5) begin
        if (s1 == DEPTH) n++;
        else q1.push_back(c1);
      end
      m_drop = (m_drop + n > DROP_MAX) ? DROP_MAX : m_drop + n;
    end
    cyc++;
    m_busy = (q0.size() > 0) || (q1.size() > 0) || m_valid || (cyc < idle_from);
  endtask

  task automatic step(input bit rst, input bit v0, input logic [2:0] c0,
                      input bit v1, input logic [2:0] c1, input bit rdy);
    reset = rst; p0_valid = v0; p0_cmd = c0; p1_valid = v1; p1_cmd = c1; cmd_ready = rdy;
    @(posedge clock);
    model_edge(rst, v0, int'(c0), v1, int'(c1), rdy);
    #1;
    check("cmd_valid",  cmd_valid,  m_valid);
    check("cmd_data",   cmd_data,   m_data);
    check("cmd_player", cmd_player, m_player);
    check("drop_count", drop_count, m_drop);
    check("busy",       busy,       m_busy);
  endtask

  task automatic idle_steps(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(0, 0, 3'd0, 0, 3'd0, rdy);
  endtask

  task automatic do_reset();
    step(1, 0, 3'd0, 0, 3'd0, 0);
    step(1, 0, 3'd0, 0, 3'd0, 0);
  endtask

  initial begin
    int rdy_pct;
    do_reset();
    check("reset_valid", cmd_valid, 0);
    check("reset_busy",  busy, 0);
    check("reset_drop",  drop_count, 0);

    // Single command latency and cooldown length.
    idle_steps(7, 1);
    step(0, 1, 3'd3, 0, 3'd0, 1);
    step(0, 0, 3'd0, 0, 3'd0, 1);
    check("lat_valid", cmd_valid, 1);
    check("lat_data", cmd_data, 3);
    check("lat_player", cmd_player, 0);
    step(0, 0, 3'd0, 0, 3'd0, 1);
    check("hs_valid_low", cmd_valid, 0);
    idle_steps(GAP - 1, 1);
    check("cool_busy", busy, 1);
    idle_steps(1, 1);
    check("cool_done_busy", busy, 0);

    // Simultaneous strobes: player 0 first, player 1 GAP+2 cycles later.
    do_reset();
    step(0, 1, 3'd0, 1, 3'd4, 1);
    step(0, 0, 3'd0, 0, 3'd0, 1);
    check("rr_first_player", cmd_player, 0);
    check("rr_first_data", cmd_data, 0);
    idle_steps(GAP + 1, 1);
    check("rr_second_early", cmd_valid, 0);
    idle_steps(1, 1);
    check("rr_second_valid", cmd_valid, 1);
    check("rr_second_player", cmd_player, 1);
    check("rr_second_data", cmd_data, 4);
    idle_steps(GAP + 4, 1);

    // Overflow: arbiter held in PRESENT while player 1 sends six codes.
    do_reset();
    step(0, 1, 3'd2, 0, 3'd0, 0);
    step(0, 0, 3'd0, 0, 3'd0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 3'd0, 1, 3'(i), 0);
    check("ovf_drop", drop_count, 2);
    idle_steps(60, 1);

    // Long stall: outputs held, accepted once when ready rises.
    step(0, 1, 3'd5, 0, 3'd0, 0);
    idle_steps(50, 0);
    check("stall_valid", cmd_valid, 1);
    check("stall_data", cmd_data, 5);
    step(0, 0, 3'd0, 0, 3'd0, 1);
    check("stall_released", cmd_valid, 0);
    idle_steps(GAP + 3, 1);

    // Reserved codes are ignored entirely.
    step(0, 1, 3'd6, 0, 3'd0, 1);
    step(0, 1, 3'd7, 1, 3'd7, 1);
    idle_steps(2, 1);
    check("bad_code_busy", busy, 0);
    check("bad_code_valid", cmd_valid, 0);

    // Reset while presenting with three entries buffered per player.
    step(0, 1, 3'd1, 0, 3'd0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 3'(i), 1, 3'(i + 2), 0);
    check("pre_reset_valid", cmd_valid, 1);
    step(1, 0, 3'd0, 0, 3'd0, 0);
    check("mid_reset_valid", cmd_valid, 0);
    check("mid_reset_busy", busy, 0);
    check("mid_reset_drop", drop_count, 0);
    step(0, 1, 3'd4, 0, 3'd0, 1);
    step(0, 0, 3'd0, 0, 3'd0, 1);
    check("post_reset_valid", cmd_valid, 1);
    check("post_reset_data", cmd_data, 4);
    idle_steps(GAP + 3, 1);

    // Random traffic with varying back-pressure and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 0) rdy_pct = 10 + 20 * int'($urandom_range(0, 4));
      step(($urandom_range(0, 399) == 0),
           ($urandom_range(0, 99) < 25), 3'($urandom_range(0, 7)),
           ($urandom_range(0, 99) < 25), 3'($urandom_range(0, 7)),
           ($urandom_range(0, 99) < rdy_pct));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
